// File: rtl/sdpram_bist_engine.sv
// sdpram_bist_engine: fill / read-back / compare BIST sequencer for simple-dual-port RAMs
module sdpram_bist_engine #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int BE_WIDTH      = 4,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 3
) (
    input  logic                     wr_clk,
    input  logic                     tb_wr_rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic                     mem_wr_en,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    output logic [DATA_WIDTH-1:0]    mem_wr_data,
    output logic [BE_WIDTH-1:0]      mem_wr_byte_en,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rd_data
);
    typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DRAIN, DONE} state_t;
    state_t                  state, state_nxt;
    logic [ADDR_WIDTH:0]     cnt, cnt_nxt;
    logic [1:0]              mode_q;
    logic [RD_LATENCY-1:0]   vld_pipe;
    logic [ADDR_WIDTH-1:0]   addr_pipe [RD_LATENCY];
    logic                    accept;
    logic                    mismatch;

    // Pattern word for address a; the 0xA..A base is truncated/extended to DATA_WIDTH
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m, input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] ext;
        logic [DATA_WIDTH-1:0] alt;
        ext = DATA_WIDTH'(a);
        alt = DATA_WIDTH'({(DATA_WIDTH + 1) / 2{2'b10}});
        return m == 2'd0 ? ~ext : m == 2'd1 ? ext : (a[0] ^ m[0]) ? ~alt : alt;
    endfunction

    assign accept         = start && (state == IDLE || state == DONE);
    assign busy           = state != IDLE && state != DONE;
    assign done           = state == DONE;
    assign pass           = done && err_cnt == '0;
    assign mem_wr_en      = state == WRITE;
    assign mem_wr_addr    = mem_wr_en ? cnt[ADDR_WIDTH-1:0] : '0;
    assign mem_wr_data    = mem_wr_en ? pattern(mode_q, cnt[ADDR_WIDTH-1:0]) : '0;
    assign mem_wr_byte_en = {BE_WIDTH{mem_wr_en}};
    assign mem_rd_en      = state == READ;
    assign mem_rd_addr    = mem_rd_en ? cnt[ADDR_WIDTH-1:0] : '0;
    assign mismatch       = vld_pipe[RD_LATENCY-1] &&
                            mem_rd_data != pattern(mode_q, addr_pipe[RD_LATENCY-1]);

    // Next state and address/drain counter; the counter MSB marks the wrap out of WRITE/READ
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            IDLE, DONE: begin
                cnt_nxt = '0;
                if (start) state_nxt = WRITE;
            end
            WRITE: if (cnt_nxt[ADDR_WIDTH]) begin
                state_nxt = GAP;
                cnt_nxt   = '0;
            end
            GAP: begin
                state_nxt = READ;
                cnt_nxt   = '0;
            end
            READ: if (cnt_nxt[ADDR_WIDTH]) begin
                state_nxt = DRAIN;
                cnt_nxt   = '0;
            end
            DRAIN: if (cnt == (ADDR_WIDTH + 1)'(RD_LATENCY)) begin
                state_nxt = DONE;
                cnt_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and latched pattern mode
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) mode_q <= mode;
        end
    end

    // Read-valid/address pipeline aligned with the RAM read latency
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) addr_pipe[i] <= '0;
        end else begin
            vld_pipe[0]  <= mem_rd_en;
            addr_pipe[0] <= mem_rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    // Saturating mismatch counter; first failing address captured on the 0 -> 1 step only
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (accept) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) first_err_addr <= addr_pipe[RD_LATENCY-1];
        end
    end
endmodule

// File: tb/tb_sdpram_bist_engine.sv
// tb_sdpram_bist_engine: randomized self-checking bench, one DUT at read latency 1 and one at 2
module tb_sdpram_bist_engine;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int N  = 512;

    logic          wr_clk = 1'b0;
    logic          tb_wr_rst;
    logic          start;
    logic [1:0]    mode;
    logic          busy1, done1, pass1, we1, re1, busy2, done2, pass2, we2, re2;
    logic [2:0]    err1, err2;
    logic [AW-1:0] fea1, wa1, ra1, fea2, wa2, ra2;
    logic [DW-1:0] wd1, rd1, wd2, rd2;
    logic [3:0]    be1, be2;
    logic [DW-1:0] ram1 [N];
    logic [DW-1:0] ram2 [N];
    logic [DW-1:0] q2a;
    int            fault;
    logic [AW-1:0] fault_addr;
    int            checks = 0;
    int            failures = 0;

    always #5 wr_clk = ~wr_clk;

    sdpram_bist_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(4), .RD_LATENCY(1), .ERR_CNT_WIDTH(3)) u1 (
        .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .start(start), .mode(mode),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(fea1),
        .mem_wr_en(we1), .mem_wr_addr(wa1), .mem_wr_data(wd1), .mem_wr_byte_en(be1),
        .mem_rd_en(re1), .mem_rd_addr(ra1), .mem_rd_data(rd1));

    sdpram_bist_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(4), .RD_LATENCY(2), .ERR_CNT_WIDTH(3)) u2 (
        .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .start(start), .mode(mode),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_err_addr(fea2),
        .mem_wr_en(we2), .mem_wr_addr(wa2), .mem_wr_data(wd2), .mem_wr_byte_en(be2),
        .mem_rd_en(re2), .mem_rd_addr(ra2), .mem_rd_data(rd2));

    // Expected pattern straight from the pattern table
    function automatic logic [DW-1:0] ref_data(input int m, input int a);
        case (m)
            0:       return 32'hFFFF_FFFF - 32'(a);
            1:       return 32'(a);
            2:       return (a % 2) ? 32'h5555_5555 : 32'hAAAA_AAAA;
            default: return (a % 2) ? 32'hAAAA_AAAA : 32'h5555_5555;
        endcase
    endfunction

    // Injected RAM defect: 1 = bit 0 flipped at fault_addr, 2 = data bus stuck at 0
    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] d, input int a);
        if (fault == 1 && a == int'(fault_addr)) return d ^ 32'd1;
        if (fault == 2) return '0;
        return d;
    endfunction

    // Expected error count (saturating at 7) and first failing address over a full pass
    task automatic exp_model(input int m, output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int a = 0; a < N; a++)
            if (faulty(ref_data(m, a), a) !== ref_data(m, a)) begin
                if (cnt == 0) first = a;
                cnt++;
            end
        if (cnt > 7) cnt = 7;
    endtask

    always @(posedge wr_clk) begin
        if (we1) ram1[wa1] <= wd1;
        if (re1) rd1 <= faulty(ram1[ra1], int'(ra1));
    end

    always @(posedge wr_clk) begin
        if (we2) ram2[wa2] <= wd2;
        if (re2) q2a <= faulty(ram2[ra2], int'(ra2));
        rd2 <= q2a;
    end

    // Runs one test on both DUTs; returns busy lengths (-1 on timeout) and bad write-port words
    task automatic run(input logic [1:0] m, output int b1, output int b2, output int wbad);
        int wn;
        b1 = 0; b2 = 0; wbad = 0; wn = 0;
        @(negedge wr_clk); start = 1'b1; mode = m;
        @(negedge wr_clk); start = 1'b0;
        for (int t = 0; t < 3000 && !(done1 && done2); t++) begin
            if (busy1) b1++;
            if (busy2) b2++;
            if (we1) begin
                if (wa1 !== wn[AW-1:0] || wd1 !== ref_data(int'(m), wn) || be1 !== 4'hF) wbad++;
                wn++;
            end
            @(negedge wr_clk);
        end
        if (!(done1 && done2)) b1 = -1;
        if (wn != N) wbad++;
    endtask

    task automatic test_reset();
        tb_wr_rst = 1'b1; start = 1'b0; mode = 2'd0; fault = 0; fault_addr = '0;
        repeat (3) @(negedge wr_clk);
        checks++; if ({busy1, done1, pass1, err1, fea1, we1, wa1, wd1, be1, re1, ra1} !== '0) begin failures++; $display("FAIL reset_u1 outputs not all zero busy=%b done=%b we=%b re=%b err=%0d", busy1, done1, we1, re1, err1); end
        checks++; if ({busy2, done2, pass2, err2, fea2, we2, wa2, wd2, be2, re2, ra2} !== '0) begin failures++; $display("FAIL reset_u2 outputs not all zero busy=%b done=%b we=%b re=%b err=%0d", busy2, done2, we2, re2, err2); end
        tb_wr_rst = 1'b0;
        repeat (2) @(negedge wr_clk);
        checks++; if ({busy1, done1, we1, re1} !== 4'b0) begin failures++; $display("FAIL idle_hold got=%b exp=0000", {busy1, done1, we1, re1}); end
    endtask

    task automatic test_mode0();
        int b1, b2, wbad;
        fault = 0;
        run(2'd0, b1, b2, wbad);
        checks++; if (b1 !== 1027) begin failures++; $display("FAIL mode0_busy_lat1 got=%0d exp=1027", b1); end
        checks++; if (wbad !== 0) begin failures++; $display("FAIL mode0_writes bad=%0d exp=0", wbad); end
        checks++; if (ram1[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mode0_addr0 got=%h exp=ffffffff", ram1[0]); end
        checks++; if (ram1[511] !== 32'hFFFF_FE00) begin failures++; $display("FAIL mode0_addr1ff got=%h exp=fffffe00", ram1[511]); end
        checks++; if ({done1, pass1, err1} !== 5'b11000) begin failures++; $display("FAIL mode0_result done=%b pass=%b err=%0d exp 1/1/0", done1, pass1, err1); end
    endtask

    task automatic test_lat2();
        int b1, b2, wbad;
        fault = 0;
        run(2'd2, b1, b2, wbad);
        checks++; if (b2 !== 1028) begin failures++; $display("FAIL lat2_busy got=%0d exp=1028", b2); end
        checks++; if (ram2[0] !== 32'hAAAA_AAAA || ram2[1] !== 32'h5555_5555) begin failures++; $display("FAIL lat2_data got=%h/%h exp=aaaaaaaa/55555555", ram2[0], ram2[1]); end
        checks++; if ({pass2, err2} !== 4'b1000) begin failures++; $display("FAIL lat2_pass pass=%b err=%0d exp 1/0", pass2, err2); end
        checks++; if ({pass1, err1} !== 4'b1000 || wbad !== 0) begin failures++; $display("FAIL lat2_u1 pass=%b err=%0d wbad=%0d exp 1/0/0", pass1, err1, wbad); end
    endtask

    task automatic test_bitflip();
        int b1, b2, wbad;
        fault = 1; fault_addr = 9'h005;
        run(2'd1, b1, b2, wbad);
        checks++; if (err1 !== 3'd1 || fea1 !== 9'h005 || pass1 !== 1'b0) begin failures++; $display("FAIL flip_u1 err=%0d first=%h pass=%b exp 1/005/0", err1, fea1, pass1); end
        checks++; if (err2 !== 3'd1 || fea2 !== 9'h005 || pass2 !== 1'b0) begin failures++; $display("FAIL flip_u2 err=%0d first=%h pass=%b exp 1/005/0", err2, fea2, pass2); end
    endtask

    task automatic test_stuck();
        int b1, b2, wbad;
        fault = 2;
        run(2'd3, b1, b2, wbad);
        checks++; if (err1 !== 3'b111 || fea1 !== 9'h000 || pass1 !== 1'b0) begin failures++; $display("FAIL stuck_u1 err=%0d first=%h pass=%b exp 7/000/0", err1, fea1, pass1); end
        checks++; if (err2 !== 3'b111 || fea2 !== 9'h000) begin failures++; $display("FAIL stuck_u2 err=%0d first=%h exp 7/000", err2, fea2); end
        checks++; if (b1 !== 1027 || b2 !== 1028) begin failures++; $display("FAIL stuck_busy got=%0d/%0d exp=1027/1028", b1, b2); end
    endtask

    task automatic test_random();
        int b1, b2, wbad, ec, ef;
        logic [1:0] m;
        for (int k = 0; k < 4; k++) begin
            m = 2'($urandom_range(0, 3));
            fault = int'($urandom_range(0, 1));
            fault_addr = 9'($urandom_range(0, N - 1));
            exp_model(int'(m), ec, ef);
            run(m, b1, b2, wbad);
            checks++; if (int'(err1) !== ec || (ec != 0 && int'(fea1) !== ef) || pass1 !== (ec == 0)) begin failures++; $display("FAIL rand%0d_u1 mode=%0d err=%0d first=%h exp err=%0d first=%h", k, m, err1, fea1, ec, ef); end
            checks++; if (int'(err2) !== ec || (ec != 0 && int'(fea2) !== ef) || pass2 !== (ec == 0)) begin failures++; $display("FAIL rand%0d_u2 mode=%0d err=%0d first=%h exp err=%0d first=%h", k, m, err2, fea2, ec, ef); end
            checks++; if (wbad !== 0 || b1 !== 1027 || b2 !== 1028) begin failures++; $display("FAIL rand%0d_seq wbad=%0d busy=%0d/%0d exp 0/1027/1028", k, wbad, b1, b2); end
        end
    endtask

    task automatic test_reset_mid();
        int b1, b2, wbad, t;
        fault = 0;
        @(negedge wr_clk); start = 1'b1; mode = 2'($urandom_range(0, 3));
        @(negedge wr_clk); start = 1'b0;
        for (t = 0; t < 3000 && !(re1 && ra1 == 9'h100); t++) @(negedge wr_clk);
        checks++; if (t >= 3000) begin failures++; $display("FAIL midrst_reach read addr 100 not seen within %0d cycles", t); end
        tb_wr_rst = 1'b1;
        #1;
        checks++; if ({busy1, done1, we1, re1, err1} !== 7'b0) begin failures++; $display("FAIL midrst_u1 busy=%b done=%b we=%b re=%b err=%0d exp all 0", busy1, done1, we1, re1, err1); end
        checks++; if ({busy2, done2, we2, re2, err2} !== 7'b0) begin failures++; $display("FAIL midrst_u2 busy=%b done=%b we=%b re=%b err=%0d exp all 0", busy2, done2, we2, re2, err2); end
        @(negedge wr_clk); tb_wr_rst = 1'b0;
        run(2'($urandom_range(0, 3)), b1, b2, wbad);
        checks++; if (pass1 !== 1'b1 || pass2 !== 1'b1 || wbad !== 0) begin failures++; $display("FAIL midrst_rerun pass=%b/%b wbad=%0d exp 1/1/0", pass1, pass2, wbad); end
    endtask

    task automatic test_back_to_back();
        int t;
        fault = 2;
        @(negedge wr_clk); start = 1'b1; mode = 2'd3;
        @(negedge wr_clk); start = 1'b0;
        repeat (20) @(negedge wr_clk);
        start = 1'b1; mode = 2'd1;
        @(negedge wr_clk); start = 1'b0;
        for (t = 0; t < 3000 && !(done1 && done2); t++) @(negedge wr_clk);
        checks++; if (t >= 3000) begin failures++; $display("FAIL b2b_timeout no done within %0d cycles", t); end
        checks++; if (ram1[0] !== 32'h5555_5555 || ram1[3] !== 32'hAAAA_AAAA || err1 !== 3'b111) begin failures++; $display("FAIL b2b_ignored data=%h/%h err=%0d exp 55555555/aaaaaaaa/7", ram1[0], ram1[3], err1); end
        fault = 0;
        start = 1'b1; mode = 2'd1;
        @(negedge wr_clk); start = 1'b0;
        checks++; if ({busy1, done1, err1, we1} !== 6'b100001 || wa1 !== 9'h000 || wd1 !== 32'h0) begin failures++; $display("FAIL b2b_restart busy=%b done=%b err=%0d we=%b addr=%h data=%h exp 1/0/0/1/000/00000000", busy1, done1, err1, we1, wa1, wd1); end
        for (t = 0; t < 3000 && !(done1 && done2); t++) @(negedge wr_clk);
        checks++; if (pass1 !== 1'b1 || pass2 !== 1'b1 || ram1[7] !== 32'd7) begin failures++; $display("FAIL b2b_final pass=%b/%b data7=%h exp 1/1/00000007", pass1, pass2, ram1[7]); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_lat2();
        test_bitflip();
        test_stuck();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
